rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of writeback requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: register address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: register data width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port flush, input, 1: discard all buffered writes.
REQ-007 SHALL have port req_valid, input, NUM_REQ: per-requester write request.
REQ-008 SHALL have port req_ready, output, NUM_REQ: per-requester accept.
REQ-009 SHALL have port req_addr, input, NUM_REQ x ADDR_WIDTH: destination register per requester.
REQ-010 SHALL have port req_data, input, NUM_REQ x DATA_WIDTH: write data per requester.
REQ-011 SHALL have port wr, data_write_interface.write modport (wen 1, addr ADDR_WIDTH, data DATA_WIDTH): drives one reg_file write port.
REQ-012 SHALL have port q_addr, input, ADDR_WIDTH: hazard query address.
REQ-013 SHALL have port q_busy, output, 1: a buffered write to q_addr is pending.

Function
REQ-014 SHALL hold one slot per requester (valid, addr, data); a slot loads on req_valid[i] & req_ready[i].
REQ-015 SHALL accept and discard requests with req_addr == 0, without loading the slot and with req_ready[i] = 1 (flush excepted).
REQ-016 SHALL each cycle grant at most one valid slot, round-robin from pointer ptr (ptr, ptr+1, ... mod NUM_REQ).
REQ-017 SHALL after a grant set ptr = granted index + 1 mod NUM_REQ, and leave ptr unchanged when there is no grant.
REQ-018 SHALL drive wr.wen = 1, wr.addr/wr.data from the granted slot, combinationally from slot state only; accept-to-wen latency is 1 cycle minimum.
REQ-019 SHALL drive wr.wen = 0 and wr.addr/wr.data = 0 when there is no grant.
REQ-020 SHALL set req_ready[i] = (~slot_valid[i] | grant[i]) & ~flush & ~waw_block[i]; a slot granted in a cycle may reload in that same cycle.
REQ-021 SHALL set waw_block[i] when req_addr[i] != 0 equals the addr of any other valid slot not granted this cycle, or of any lower-index requester accepted this cycle, so same-register writes retire in acceptance order.
REQ-022 SHALL set q_busy = 1 iff q_addr != 0 and some valid slot holds addr q_addr, including the slot granted this cycle.
REQ-023 SHALL, on flush, force wr.wen = 0 and req_ready = 0 that cycle, then clear all slots and set ptr = 0 at the next edge.
REQ-024 SHALL, when all slots are full with no flush, still grant one slot per cycle and free exactly that slot.

Reset
REQ-025 SHALL, when rst is sampled high, clear all slot valid bits, set ptr = 0, and discard in-flight acceptances; outputs are then wr.wen = 0, q_busy = 0, and req_ready = all ones unless waw_block applies (none after reset).
REQ-026 SHALL give rst priority over flush and over acceptance in the same cycle.

Structure
REQ-027 SHALL place NUM_REQ limits and the slot struct typedef (valid, addr, data) in the shared common package.
REQ-028 SHALL use one combinational sub-module, rr_pick (inputs request vector and ptr, output one-hot grant and index), reusable by other arbiters.

Verification
REQ-029 SHALL cover: after reset, req_valid = 4'b0001, addr 5, data 0xA5 -> wr.wen = 1, addr 5, data 0xA5 on the next cycle, then wen = 0.
REQ-030 SHALL cover: all 4 requesters valid with addrs 1..4 in one cycle, ptr = 0 -> wr.addr sequence 1, 2, 3, 4 on 4 consecutive cycles; ptr returns to 0.
REQ-031 SHALL cover: req 0 and req 2 both addr 7 in the same cycle -> req_ready = 4'b1011; req 2 is accepted only after req 0's write is granted, and wr.data follows acceptance order.
REQ-032 SHALL cover: request with addr 0 -> req_ready = 1 and wr.wen never asserts.
REQ-033 SHALL cover: 3 slots loaded, flush = 1 -> wen = 0 that cycle and no writes afterwards; q_busy = 0 for the flushed addrs.
REQ-034 SHALL cover: slot 1 holds addr 9, q_addr = 9 -> q_busy = 1 until the cycle after slot 1 is granted; rst asserted with slots full -> all cleared next cycle.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: requester limits
// and the per-requester buffered write slot.
package rf_write_arbiter_pkg;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  // Slot fields are sized for the widest supported configuration; instances
  // zero-extend into them and read back only their configured low bits.
  localparam int SLOT_ADDR_MAX = 16;
  localparam int SLOT_DATA_MAX = 64;

  typedef struct packed {
    logic                     valid;
    logic [SLOT_ADDR_MAX-1:0] addr;
    logic [SLOT_DATA_MAX-1:0] data;
  } slot_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Single register-file write port: enable, destination register and data.
interface data_write_interface #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);

  logic                  wen;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  modport write  (output wen, addr, data);
  modport read   (input  wen, addr, data);
  modport master (output wen, addr, data);
  modport slave  (input  wen, addr, data);

endinterface

// File: rtl/rf_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N, returned as a one-hot grant plus its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Buffers one writeback per requester and retires them round-robin onto a
// single register-file write port, keeping same-register writes in order.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  data_write_interface.write                   wr,
  input  logic [ADDR_WIDTH-1:0]                q_addr,
  output logic                                 q_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("rf_write_arbiter: NUM_REQ out of range");
  end
  if (ADDR_WIDTH > SLOT_ADDR_MAX || DATA_WIDTH > SLOT_DATA_MAX) begin : g_bad_width
    $error("rf_write_arbiter: width exceeds slot storage");
  end

  slot_t              slot_q [NUM_REQ];
  logic [PTR_W-1:0]   ptr_q;

  logic [NUM_REQ-1:0] slot_valid;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gidx;
  logic               gany;
  logic [NUM_REQ-1:0] waw_block;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] load;

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) slot_valid[j] = slot_q[j].valid;
  end

  // Flush suppresses the grant so nothing reaches the register file that cycle.
  assign pick_req = flush ? '0 : slot_valid;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (PTR_W)
  ) u_rr_pick (
    .req   (pick_req),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  always_comb begin
    wr.wen  = gany;
    wr.addr = '0;
    wr.data = '0;
    if (gany) begin
      wr.addr = slot_q[gidx].addr[ADDR_WIDTH-1:0];
      wr.data = slot_q[gidx].data[DATA_WIDTH-1:0];
    end
  end

  // Requesters are resolved in index order so a lower-index acceptance can
  // hold off a same-register request from a higher index in the same cycle.
  always_comb begin
    waw_block = '0;
    req_ready = '0;
    accept    = '0;
    load      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_addr[i] != '0) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (j != i && slot_valid[j] && !grant[j] &&
              slot_q[j].addr == SLOT_ADDR_MAX'(req_addr[i]))
            waw_block[i] = 1'b1;
          if (j < i && accept[j] && req_addr[j] == req_addr[i])
            waw_block[i] = 1'b1;
        end
      end
      req_ready[i] = (~slot_valid[i] | grant[i]) & ~flush & ~waw_block[i];
      accept[i]    = req_valid[i] & req_ready[i];
      load[i]      = accept[i] & (req_addr[i] != '0);
    end
  end

  always_comb begin
    q_busy = 1'b0;
    if (q_addr != '0) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (slot_valid[j] && slot_q[j].addr == SLOT_ADDR_MAX'(q_addr))
          q_busy = 1'b1;
      end
    end
  end

  // Slot payload is not reset; only valid bits and the pointer are.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (load[i]) begin
        slot_q[i].addr <= SLOT_ADDR_MAX'(req_addr[i]);
        slot_q[i].data <= SLOT_DATA_MAX'(req_data[i]);
      end
    end
    if (rst || flush) begin
      for (int i = 0; i < NUM_REQ; i++) slot_q[i].valid <= 1'b0;
      ptr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load[i])       slot_q[i].valid <= 1'b1;
        else if (grant[i]) slot_q[i].valid <= 1'b0;
      end
      if (gany)
        ptr_q <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus randomized traffic
// against a behavioural slot model and a per-register write-order scoreboard.
module tb_rf_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][DW-1:0]   req_data;
  logic [AW-1:0]          q_addr;
  logic                   q_busy;

  data_write_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wr_if ();

  rf_write_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr        (wr_if),
    .q_addr    (q_addr),
    .q_busy    (q_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: pending writes per requester plus a retire pointer.
  int            m_valid [N];
  int            m_addr  [N];
  logic [DW-1:0] m_data  [N];
  int            m_ptr;
  int            e_gnt;
  logic [N-1:0]  e_rdy;
  logic [N-1:0]  e_acc;
  logic          e_busy;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t order_q[$];

  task automatic model_eval();
    e_gnt = -1;
    if (!flush) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (e_gnt < 0 && m_valid[c] != 0) e_gnt = c;
      end
    end
    e_rdy = '0;
    e_acc = '0;
    for (int i = 0; i < N; i++) begin
      bit blk;
      int a;
      blk = 1'b0;
      a   = int'(req_addr[i]);
      if (a != 0) begin
        for (int j = 0; j < N; j++) begin
          if (j != i && m_valid[j] != 0 && j != e_gnt && m_addr[j] == a) blk = 1'b1;
          if (j < i && e_acc[j] && int'(req_addr[j]) == a) blk = 1'b1;
        end
      end
      e_rdy[i] = (m_valid[i] == 0 || e_gnt == i) && !flush && !blk;
      e_acc[i] = req_valid[i] && e_rdy[i];
    end
    e_busy = 1'b0;
    if (q_addr != '0) begin
      for (int j = 0; j < N; j++)
        if (m_valid[j] != 0 && m_addr[j] == int'(q_addr)) e_busy = 1'b1;
    end
  endtask

  task automatic check_outputs();
    model_eval();
    chk("wen",    64'(wr_if.wen), 64'(e_gnt >= 0));
    chk("addr",   64'(wr_if.addr), (e_gnt >= 0) ? 64'(m_addr[e_gnt]) : 64'd0);
    chk("data",   64'(wr_if.data), (e_gnt >= 0) ? 64'(m_data[e_gnt]) : 64'd0);
    chk("ready",  64'(req_ready), 64'(e_rdy));
    chk("q_busy", 64'(q_busy), 64'(e_busy));
    if (wr_if.wen === 1'b1) begin
      int hit;
      hit = -1;
      for (int k = 0; k < order_q.size(); k++)
        if (hit < 0 && order_q[k].addr == int'(wr_if.addr)) hit = k;
      if (hit >= 0) begin
        chk("order", 64'(wr_if.data), 64'(order_q[hit].data));
        order_q.delete(hit);
      end else begin
        chk("order_pending", 64'd0, 64'd1);
      end
    end
  endtask

  task automatic model_step();
    if (rst || flush) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_ptr = 0;
      order_q.delete();
    end else begin
      if (e_gnt >= 0) begin
        m_valid[e_gnt] = 0;
        m_ptr = (e_gnt + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (e_acc[i] && req_addr[i] != '0) begin
          wr_t w;
          m_valid[i] = 1;
          m_addr[i]  = int'(req_addr[i]);
          m_data[i]  = req_data[i];
          w.addr = int'(req_addr[i]);
          w.data = req_data[i];
          order_q.push_back(w);
        end
      end
    end
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0][AW-1:0] a,
                     input logic [N-1:0][DW-1:0] d, input logic fl, input logic r,
                     input logic [AW-1:0] q);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    flush     = fl;
    rst       = r;
    q_addr    = q;
    #1;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  logic [N-1:0][AW-1:0] sa;
  logic [N-1:0][DW-1:0] sd;

  task automatic do_reset();
    cyc('0, '0, '0, 1'b0, 1'b1, '0);
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; q_addr = '0;
    for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_addr[i] = 0; m_data[i] = '0; end
    m_ptr = 0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);

    // Reset state
    cyc('0, '0, '0, 1'b0, 1'b0, 6'd5);
    chk("rst_wen", 64'(wr_if.wen), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'hF);
    chk("rst_busy", 64'(q_busy), 64'd0);
    tick();

    // Single write, one cycle to wen
    do_reset();
    sa = '0; sd = '0; sa[0] = 6'd5; sd[0] = 32'hA5;
    cyc(4'b0001, sa, sd, 1'b0, 1'b0, '0);
    chk("t1_ready", 64'(req_ready[0]), 64'd1);
    chk("t1_wen_early", 64'(wr_if.wen), 64'd0);
    tick();
    cyc('0, sa, sd, 1'b0, 1'b0, '0);
    chk("t1_wen", 64'(wr_if.wen), 64'd1);
    chk("t1_addr", 64'(wr_if.addr), 64'd5);
    chk("t1_data", 64'(wr_if.data), 64'hA5);
    tick();
    cyc('0, sa, sd, 1'b0, 1'b0, '0);
    chk("t1_idle", 64'(wr_if.wen), 64'd0);
    tick();

    // All four at once retire 1,2,3,4; pointer wraps back to requester 0
    do_reset();
    for (int i = 0; i < N; i++) begin sa[i] = AW'(i + 1); sd[i] = $urandom; end
    cyc(4'hF, sa, sd, 1'b0, 1'b0, '0);
    tick();
    for (int k = 0; k < N; k++) begin
      cyc('0, sa, sd, 1'b0, 1'b0, '0);
      chk("rr_addr", 64'(wr_if.addr), 64'(k + 1));
      tick();
    end
    sa = '0; sa[0] = 6'd20; sa[1] = 6'd21;
    cyc(4'b0011, sa, sd, 1'b0, 1'b0, '0);
    tick();
    cyc('0, sa, sd, 1'b0, 1'b0, '0);
    chk("rr_wrap", 64'(wr_if.addr), 64'd20);
    tick();
    cyc('0, sa, sd, 1'b0, 1'b0, '0);
    tick();

    // Same register from requesters 0 and 2
    do_reset();
    sa = '0; sd = '0; sa[0] = 6'd7; sa[2] = 6'd7; sd[0] = 32'hD0D0; sd[2] = 32'hD2D2;
    cyc(4'b0101, sa, sd, 1'b0, 1'b0, '0);
    chk("waw_ready", 64'(req_ready), 64'b1011);
    tick();
    cyc(4'b0100, sa, sd, 1'b0, 1'b0, '0);
    chk("waw_first", 64'(wr_if.data), 64'hD0D0);
    chk("waw_ready2", 64'(req_ready[2]), 64'd1);
    tick();
    cyc('0, sa, sd, 1'b0, 1'b0, '0);
    chk("waw_second", 64'(wr_if.data), 64'hD2D2);
    tick();

    // Register 0 is accepted and dropped
    do_reset();
    sa = '0;
    cyc(4'b0010, sa, sd, 1'b0, 1'b0, '0);
    chk("zero_ready", 64'(req_ready[1]), 64'd1);
    tick();
    for (int k = 0; k < 2; k++) begin
      cyc('0, sa, sd, 1'b0, 1'b0, '0);
      chk("zero_wen", 64'(wr_if.wen), 64'd0);
      tick();
    end

    // Flush with three slots loaded
    do_reset();
    sa = '0; sa[0] = 6'd10; sa[1] = 6'd11; sa[2] = 6'd12;
    cyc(4'b0111, sa, sd, 1'b0, 1'b0, '0);
    tick();
    cyc('0, sa, sd, 1'b1, 1'b0, 6'd10);
    chk("fl_wen", 64'(wr_if.wen), 64'd0);
    chk("fl_ready", 64'(req_ready), 64'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      cyc('0, sa, sd, 1'b0, 1'b0, AW'(10 + k));
      chk("fl_after_wen", 64'(wr_if.wen), 64'd0);
      chk("fl_after_busy", 64'(q_busy), 64'd0);
      tick();
    end

    // Hazard query follows slot 1 until it retires
    do_reset();
    sa = '0; sa[0] = 6'd3; sa[1] = 6'd9;
    cyc(4'b0011, sa, sd, 1'b0, 1'b0, 6'd9);
    tick();
    cyc('0, sa, sd, 1'b0, 1'b0, 6'd9);
    chk("qb_wait", 64'(q_busy), 64'd1);
    tick();
    cyc('0, sa, sd, 1'b0, 1'b0, 6'd9);
    chk("qb_grant", 64'(q_busy), 64'd1);
    chk("qb_grant_addr", 64'(wr_if.addr), 64'd9);
    tick();
    cyc('0, sa, sd, 1'b0, 1'b0, 6'd9);
    chk("qb_done", 64'(q_busy), 64'd0);
    tick();

    // Reset with every slot full
    do_reset();
    for (int i = 0; i < N; i++) sa[i] = AW'(40 + i);
    cyc(4'hF, sa, sd, 1'b0, 1'b0, '0);
    tick();
    cyc('0, sa, sd, 1'b0, 1'b1, 6'd40);
    tick();
    cyc('0, sa, sd, 1'b0, 1'b0, 6'd41);
    chk("rf_wen", 64'(wr_if.wen), 64'd0);
    chk("rf_busy", 64'(q_busy), 64'd0);
    chk("rf_ready", 64'(req_ready), 64'hF);
    tick();

    // Randomized traffic with a small address range for frequent collisions
    for (int c = 0; c < 800; c++) begin
      logic [N-1:0] v;
      v = N'($urandom);
      for (int i = 0; i < N; i++) begin
        sa[i] = AW'($urandom_range(0, 6));
        sd[i] = $urandom;
      end
      cyc(v, sa, sd, ($urandom_range(0, 29) == 0), ($urandom_range(0, 79) == 0),
          AW'($urandom_range(0, 6)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
